midi_note_decoder: RTL and testbench
====================================

MIDI_NOTE_DECODER -- requirements
Module: midi_note_decoder

Interface
REQ-001 SHALL have parameter CHANNEL, default 4'd0, the MIDI channel accepted when channel filtering is active.
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port byte_valid, input, 1 bit, which qualifies byte_data for exactly one cycle per received byte.
REQ-005 SHALL have port byte_data, input, 8 bits, the received MIDI byte.
REQ-006 SHALL have port note_vol, output, 16 bits: [15] gate, [14:8] note number, [7:0] volume.
REQ-007 SHALL have port vibrato, output, 8 bits: {1'b0, pitch-bend MSB}, where 64 means no bend.
REQ-008 SHALL have port msg_strobe, output, 1 bit, a one-cycle pulse when a complete accepted message updates the outputs.

Function
REQ-009 SHALL use parser states IDLE, DATA1 and DATA2, with a registered running-status byte rs and a data1 holding register d1.
REQ-010 SHALL classify each valid byte: data byte if [7]=0; real-time if >=8'hF8; system common if 8'hF0-8'hF7; channel status otherwise.
REQ-011 SHALL ignore real-time bytes entirely: no state, rs or output change.
REQ-012 SHALL, on a system-common byte, clear rs to invalid and go to IDLE.
REQ-013 SHALL, on a channel status byte in any state, load rs and go to DATA1; any partial message is discarded.
REQ-014 SHALL, on a data byte in IDLE or DATA1, store it in d1 and go to DATA2 if rs is valid; if rs is invalid it SHALL ignore the byte and stay in IDLE.
REQ-015 SHALL, on a data byte in DATA2, complete the message, go to DATA1 (running status) and evaluate the message in REQ-016 to REQ-019.
REQ-016 SHALL treat rs[7:4]=4'h9 with data2!=0 as note-on: note_vol <= {1'b1, d1[6:0], data2[6:0], 1'b0}.
REQ-017 SHALL treat rs[7:4]=4'h8, or 4'h9 with data2=0, as note-off: clear note_vol[15] and note_vol[7:0] only if d1 equals the current note_vol[14:8] and gate=1; otherwise outputs are unchanged and msg_strobe is not asserted.
REQ-018 SHALL treat rs[7:4]=4'hE as pitch bend: vibrato <= {1'b0, data2[6:0]}, with d1 (LSB) discarded.
REQ-019 SHALL complete all other status types (A, B, C, D) without output effect; C and D are one-data-byte messages and SHALL complete from DATA1.
REQ-020 SHALL register outputs updated in the cycle after the completing byte_valid, with msg_strobe high in that same cycle only.
REQ-021 SHALL treat a note-on while the gate is already set as last-note priority: it overwrites note and volume, gate stays 1, with no retrigger gap.
REQ-022 SHALL not assert msg_strobe for messages rejected by the channel filter, and SHALL leave outputs unchanged for them.

Reset
REQ-023 SHALL, while reset=0 and regardless of clk, force state=IDLE, rs=invalid, d1=0, note_vol=16'h0000, vibrato=8'd64 and msg_strobe=0.
REQ-024 SHALL discard any message in progress when reset is asserted; the first byte after reset release is parsed from IDLE.

Configuration
REQ-025 SHALL, with macro MIDI_OMNI_EN defined, accept channel messages on all 16 channels and ignore CHANNEL.
REQ-026 SHALL, without MIDI_OMNI_EN, complete and parse channel messages with rs[3:0]!=CHANNEL for running-status tracking but apply no output effect.

Structure
REQ-027 SHALL place in shared package midi_pkg: the state enum typedef, status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, PITCH_BEND=4'hE), the real-time and system-common thresholds, and VIBRATO_CENTER=8'd64.
REQ-028 SHALL be a single module; no sub-module is required.

Verification
REQ-029 SHALL cover: 90 3C 64 -> next cycle note_vol=16'hBCC8, one msg_strobe pulse.
REQ-030 SHALL cover: 90 3C 64 then running-status 40 50 -> note_vol=16'hC0A0; then 80 3C 00 -> unchanged, no strobe; then 80 40 00 -> note_vol=16'h4000.
REQ-031 SHALL cover: 90 3C F8 64 (real-time byte mid-message) -> note_vol=16'hBCC8; then 90 3C 00 -> note_vol=16'h3C00.
REQ-032 SHALL cover: E0 00 7F -> vibrato=8'h7F; then F0 -> rs invalid; then 00 00 -> no change, no strobe.
REQ-033 SHALL cover: 91 3C 64 without MIDI_OMNI_EN (CHANNEL=0) -> no change; with MIDI_OMNI_EN -> note_vol=16'hBCC8.
REQ-034 SHALL cover: 90 3C, then reset pulse, then 64 -> ignored; outputs stay note_vol=16'h0000 and vibrato=8'd64.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI note decoder.
//   state_e        : parser states (IDLE, DATA1, DATA2)
//   status nibbles : NOTE_OFF, NOTE_ON, PITCH_BEND, plus one-data-byte types
//   thresholds     : RT_MIN (real-time), SYS_MIN (system common)
//   VIBRATO_CENTER : pitch-bend MSB meaning "no bend"
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA1,
    DATA2
  } state_e;

  localparam logic [3:0] NOTE_OFF      = 4'h8;
  localparam logic [3:0] NOTE_ON       = 4'h9;
  localparam logic [3:0] PITCH_BEND    = 4'hE;
  localparam logic [3:0] PROG_CHANGE   = 4'hC;
  localparam logic [3:0] CHAN_PRESSURE = 4'hD;

  localparam logic [7:0] RT_MIN         = 8'hF8;
  localparam logic [7:0] SYS_MIN        = 8'hF0;
  localparam logic [7:0] VIBRATO_CENTER = 8'd64;
  // Bit 7 clear marks the running-status register as holding no status.
  localparam logic [7:0] RS_INVALID     = 8'h00;

  // Program change and channel pressure carry a single data byte.
  function automatic logic one_data_byte(input logic [3:0] status_type);
    return (status_type == PROG_CHANGE) || (status_type == CHAN_PRESSURE);
  endfunction

endpackage

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser driving a monophonic note/volume and vibrato output.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   byte_valid : one-cycle qualifier for byte_data
//   byte_data  : received MIDI byte
//   note_vol   : [15] gate, [14:8] note number, [7:0] volume
//   vibrato    : {1'b0, pitch-bend MSB}, 64 = centre
//   msg_strobe : one-cycle pulse when an accepted message updates outputs
// Build option: define MIDI_OMNI_EN to accept all 16 channels and ignore CHANNEL.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [15:0] note_vol,
  output logic [7:0]  vibrato,
  output logic        msg_strobe
);

  state_e      state_q, state_d;
  logic [7:0]  rs_q, rs_d;
  logic [6:0]  d1_q, d1_d;
  logic [15:0] note_vol_q, note_vol_d;
  logic [7:0]  vibrato_q, vibrato_d;
  logic        strobe_q, strobe_d;

  logic complete;
  logic chan_ok;
  logic is_note_off;

`ifdef MIDI_OMNI_EN
  assign chan_ok = 1'b1;
`else
  assign chan_ok = (rs_q[3:0] == CHANNEL);
`endif

  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    d1_d        = d1_q;
    note_vol_d  = note_vol_q;
    vibrato_d   = vibrato_q;
    strobe_d    = 1'b0;
    complete    = 1'b0;
    is_note_off = 1'b0;

    if (byte_valid) begin
      if (byte_data >= RT_MIN) begin
        // Real-time bytes pass through transparently.
      end else if (byte_data >= SYS_MIN) begin
        rs_d    = RS_INVALID;
        state_d = IDLE;
      end else if (byte_data[7]) begin
        rs_d    = byte_data;
        state_d = DATA1;
      end else if (!rs_q[7]) begin
        state_d = IDLE;
      end else if (state_q == DATA2 || one_data_byte(rs_q[7:4])) begin
        complete = 1'b1;
        state_d  = DATA1;
      end else begin
        d1_d    = byte_data[6:0];
        state_d = DATA2;
      end
    end

    // byte_data is data2 (or the lone data byte) when complete is set.
    if (complete && chan_ok) begin
      case (rs_q[7:4])
        NOTE_ON: begin
          if (byte_data != 8'd0) begin
            note_vol_d = {1'b1, d1_q, byte_data[6:0], 1'b0};
            strobe_d   = 1'b1;
          end else begin
            is_note_off = 1'b1;
          end
        end
        NOTE_OFF:   is_note_off = 1'b1;
        PITCH_BEND: begin
          vibrato_d = {1'b0, byte_data[6:0]};
          strobe_d  = 1'b1;
        end
        default: ;
      endcase

      // Only the currently sounding note may release the gate.
      if (is_note_off && note_vol_q[15] && (d1_q == note_vol_q[14:8])) begin
        note_vol_d[15]  = 1'b0;
        note_vol_d[7:0] = 8'd0;
        strobe_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rs_q       <= RS_INVALID;
      d1_q       <= 7'd0;
      note_vol_q <= 16'h0000;
      vibrato_q  <= VIBRATO_CENTER;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      d1_q       <= d1_d;
      note_vol_q <= note_vol_d;
      vibrato_q  <= vibrato_d;
      strobe_q   <= strobe_d;
    end
  end

  assign note_vol   = note_vol_q;
  assign vibrato    = vibrato_q;
  assign msg_strobe = strobe_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed bench for midi_note_decoder: hand-computed expectations, one
// immediate assertion per comparison, strobe pulses counted on falling edges.
module tb_midi_note_decoder;

  logic        clk;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [15:0] note_vol;
  logic [7:0]  vibrato;
  logic        msg_strobe;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  midi_note_decoder #(.CHANNEL(4'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .note_vol   (note_vol),
    .vibrato    (vibrato),
    .msg_strobe (msg_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs change only on posedge, so falling-edge sampling is race-free.
  always @(negedge clk) if (msg_strobe) strobe_cnt = strobe_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    reset      = 1'b0;
    idle(3);
    chk("reset_note_vol", note_vol, 16'h0000);
    chk("reset_vibrato", {8'h00, vibrato}, 16'h0040);
    chk("reset_strobe", {15'd0, msg_strobe}, 16'd0);
    reset = 1'b1;
    idle(2);

    // Note-on, with strobe observed in the cycle right after the last byte.
    strobe_cnt = 0;
    send(8'h90); send(8'h3C);
    @(negedge clk);
    byte_valid = 1'b1; byte_data = 8'h64;
    @(negedge clk);
    byte_valid = 1'b0;
    chk("on_strobe_next_cycle", {15'd0, msg_strobe}, 16'd1);
    chk("on_note_vol", note_vol, 16'hBCC8);
    idle(3);
    chk("on_strobe_count", strobe_cnt[15:0], 16'd1);

    // Running status note-on.
    strobe_cnt = 0;
    send(8'h40); send(8'h50); idle(3);
    chk("rs_note_vol", note_vol, 16'hC0A0);
    chk("rs_strobe_count", strobe_cnt[15:0], 16'd1);

    // Note-off for a note that is not sounding.
    strobe_cnt = 0;
    send(8'h80); send(8'h3C); send(8'h00); idle(3);
    chk("off_other_note_vol", note_vol, 16'hC0A0);
    chk("off_other_strobe", strobe_cnt[15:0], 16'd0);

    // Note-off for the sounding note.
    strobe_cnt = 0;
    send(8'h80); send(8'h40); send(8'h00); idle(3);
    chk("off_match_note_vol", note_vol, 16'h4000);
    chk("off_match_strobe", strobe_cnt[15:0], 16'd1);

    // Real-time byte inside a message.
    strobe_cnt = 0;
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64); idle(3);
    chk("rt_mid_note_vol", note_vol, 16'hBCC8);
    chk("rt_mid_strobe", strobe_cnt[15:0], 16'd1);

    // Note-on with velocity 0 acts as note-off.
    strobe_cnt = 0;
    send(8'h90); send(8'h3C); send(8'h00); idle(3);
    chk("vel0_note_vol", note_vol, 16'h3C00);
    chk("vel0_strobe", strobe_cnt[15:0], 16'd1);

    // Pitch bend uses the MSB only.
    strobe_cnt = 0;
    send(8'hE0); send(8'h00); send(8'h7F); idle(3);
    chk("bend_vibrato", {8'h00, vibrato}, 16'h007F);
    chk("bend_note_vol", note_vol, 16'h3C00);
    chk("bend_strobe", strobe_cnt[15:0], 16'd1);

    // System common kills running status: following data is ignored.
    strobe_cnt = 0;
    send(8'hF0); send(8'h00); send(8'h00); idle(3);
    chk("sys_vibrato", {8'h00, vibrato}, 16'h007F);
    chk("sys_note_vol", note_vol, 16'h3C00);
    chk("sys_strobe", strobe_cnt[15:0], 16'd0);

    // Channel 1 note-on.
    strobe_cnt = 0;
    send(8'h91); send(8'h3C); send(8'h64); idle(3);
`ifdef MIDI_OMNI_EN
    chk("chan1_note_vol", note_vol, 16'hBCC8);
    chk("chan1_strobe", strobe_cnt[15:0], 16'd1);
`else
    chk("chan1_note_vol", note_vol, 16'h3C00);
    chk("chan1_strobe", strobe_cnt[15:0], 16'd0);
`endif

    // Control change and program change have no output effect.
    strobe_cnt = 0;
    send(8'hB0); send(8'h07); send(8'h7F);
    send(8'hC0); send(8'h05); send(8'h06); idle(3);
`ifdef MIDI_OMNI_EN
    chk("cc_pc_note_vol", note_vol, 16'hBCC8);
`else
    chk("cc_pc_note_vol", note_vol, 16'h3C00);
`endif
    chk("cc_pc_strobe", strobe_cnt[15:0], 16'd0);

    // Last-note priority: second note-on overwrites while gate held.
    strobe_cnt = 0;
    send(8'h90); send(8'h3C); send(8'h64); idle(2);
    chk("prio_first", note_vol, 16'hBCC8);
    send(8'h30); send(8'h7F); idle(3);
    chk("prio_second", note_vol, 16'hB0FE);
    chk("prio_strobe", strobe_cnt[15:0], 16'd2);

    // System common inside a message discards it.
    strobe_cnt = 0;
    send(8'h90); send(8'h3C); send(8'hF2); send(8'h64); idle(3);
    chk("sys_mid_note_vol", note_vol, 16'hB0FE);
    chk("sys_mid_strobe", strobe_cnt[15:0], 16'd0);

    // Reset mid-message: asynchronous clear, then data byte ignored.
    send(8'h90); send(8'h3C);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_note_vol", note_vol, 16'h0000);
    chk("async_rst_vibrato", {8'h00, vibrato}, 16'h0040);
    idle(2);
    reset = 1'b1;
    idle(1);
    strobe_cnt = 0;
    send(8'h64); idle(3);
    chk("post_rst_note_vol", note_vol, 16'h0000);
    chk("post_rst_vibrato", {8'h00, vibrato}, 16'h0040);
    chk("post_rst_strobe", strobe_cnt[15:0], 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
